clock_set_ctrl: RTL and testbench



---
 rtl/clock_ctrl_pkg.sv | 26 ++
 rtl/bcd_mod_counter.sv | 41 ++++
 rtl/clock_set_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the digital clock timekeeping controller.
//   mode_e      : RUN / SET_H / SET_M encodings (also the mode_o values)
//   MAX_*       : BCD field limits for hours, minutes and seconds
//   MASK_*      : per-digit blink masks in {H tens, H ones, M tens, M ones} order
//   cnt_width() : counter width for a modulus, never below 1 bit
package clock_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN   = 2'd0,
      MODE_SET_H = 2'd1,
      MODE_SET_M = 2'd2
   } mode_e;

   localparam logic [7:0] MAX_HOUR = 8'h23;
   localparam logic [7:0] MAX_MIN  = 8'h59;
   localparam logic [7:0] MAX_SEC  = 8'h59;

   localparam logic [3:0] MASK_NONE = 4'b0000;
   localparam logic [3:0] MASK_HOUR = 4'b1100;
   localparam logic [3:0] MASK_MIN  = 4'b0011;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (one field of the clock: seconds, minutes or hours).
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i, dec_i : step up / down; both together cancel
//   clr_i        : force 00, overrides any step
//   max_i        : last legal value (BCD); up past it wraps to 00, down from 00 wraps to it
//   value_o      : current value, {tens, ones}
//   carry_o      : high in the cycle an up-step wraps max_i -> 00
module bcd_mod_counter (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       clr_i,
   input  logic [7:0] max_i,
   output logic [7:0] value_o,
   output logic       carry_o
);

   logic       step_up;
   logic       step_dn;
   logic [7:0] plus_one;
   logic [7:0] minus_one;

   assign step_up = inc_i & ~dec_i & ~clr_i;
   assign step_dn = dec_i & ~inc_i & ~clr_i;
   assign carry_o = step_up & (value_o == max_i);

   always_comb begin
      if (value_o[3:0] == 4'd9) plus_one = {value_o[7:4] + 4'd1, 4'd0};
      else                      plus_one = {value_o[7:4], value_o[3:0] + 4'd1};
      if (value_o[3:0] == 4'd0) minus_one = {value_o[7:4] - 4'd1, 4'd9};
      else                      minus_one = {value_o[7:4], value_o[3:0] - 4'd1};
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)  value_o <= 8'h00;
      else if (step_up)    value_o <= (value_o == max_i) ? 8'h00 : plus_one;
      else if (step_dn)    value_o <= (value_o == 8'h00) ? max_i : minus_one;
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller: owns HH:MM:SS, the 1 Hz prescaler,
// the RUN/SET_H/SET_M mode FSM and the blink mask for the display driver.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   btn_i      : [3] mode, [2] clear seconds, [1] increment, [0] decrement
//   bcd_o      : {H tens, H ones, M tens, M ones}
//   sec_bcd_o  : {S tens, S ones}
//   mode_o     : 0 RUN, 1 SET_H, 2 SET_M
//   blink_o    : per-digit blank request, bcd_o digit order
//   sec_tick_o : one-cycle pulse for each second advance
// Build option AUTO_REPEAT_EN: holding inc/dec in a set mode auto-repeats
// after REPEAT_DLY cycles, then every REPEAT_PER cycles.
//
// state      | meaning
// MODE_RUN   | time advances from the prescaler; clear button zeroes seconds
// MODE_SET_H | time frozen; inc/dec adjust hours, hour digits blink
// MODE_SET_M | time frozen; inc/dec adjust minutes, minute digits blink
module clock_set_ctrl
   import clock_ctrl_pkg::*;
#(
   parameter int TICK_DIV   = 50000000,
`ifdef AUTO_REPEAT_EN
   parameter int REPEAT_DLY = 25000000,
   parameter int REPEAT_PER = 5000000,
`endif
   parameter int BLINK_DIV  = 12500000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [3:0]  btn_i,
   output logic [15:0] bcd_o,
   output logic [7:0]  sec_bcd_o,
   output logic [1:0]  mode_o,
   output logic [3:0]  blink_o,
   output logic        sec_tick_o
);

   localparam int TW = cnt_width(TICK_DIV);
   localparam int BW = cnt_width(BLINK_DIV);
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_DIV - 1);

   mode_e         state;
   mode_e         state_next;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    prev;
   logic [3:0]    btn_edge;
   logic          mode_edge;
   logic          inc_edge;
   logic          dec_edge;
   logic          clr_edge;
   logic          rep_inc;
   logic          rep_dec;
   logic          in_run;
   logic          in_set_h;
   logic          in_set_m;
   logic [TW-1:0] presc;
   logic          tick;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   logic [7:0]    sec_val;
   logic [7:0]    min_val;
   logic [7:0]    hour_val;
   logic          sec_carry;
   logic          min_carry;
   logic          hour_carry_unused;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= btn_i;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign btn_edge  = sync2 & ~prev;
   assign mode_edge = btn_edge[3];
   // A mode press swallows any other button edge in the same cycle.
   assign inc_edge  = ~mode_edge & (btn_edge[1] | rep_inc);
   assign dec_edge  = ~mode_edge & (btn_edge[0] | rep_dec);
   assign clr_edge  = in_run & ~mode_edge & btn_edge[2];

   assign in_run   = (state == MODE_RUN);
   assign in_set_h = (state == MODE_SET_H);
   assign in_set_m = (state == MODE_SET_M);

`ifdef AUTO_REPEAT_EN
   localparam int RW = cnt_width((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
   localparam logic [RW-1:0] DLY_LOAD = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PER - 1);

   logic [RW-1:0] hold_cnt;
   logic          hold_single;
   logic          hold_same;
   logic          rep_fire;

   // The hold only counts while exactly one of inc/dec is down and the
   // pattern is unchanged from last cycle; any change restarts the delay.
   assign hold_single = ~in_run & (sync2[1] ^ sync2[0]);
   assign hold_same   = (sync2[1:0] == prev[1:0]);
   assign rep_fire    = hold_single & hold_same & ~mode_edge & (hold_cnt == '0);
   assign rep_inc     = rep_fire & sync2[1];
   assign rep_dec     = rep_fire & sync2[0];

   always_ff @(posedge clk_i) begin
      if (rst_i || !hold_single || !hold_same || mode_edge) hold_cnt <= DLY_LOAD;
      else if (hold_cnt == '0)                               hold_cnt <= PER_LOAD;
      else                                                   hold_cnt <= hold_cnt - RW'(1);
   end
`else
   assign rep_inc = 1'b0;
   assign rep_dec = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= MODE_RUN;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      blink_o    = MASK_NONE;
      if (mode_edge) begin
         case (state)
            MODE_RUN:   state_next = MODE_SET_H;
            MODE_SET_H: state_next = MODE_SET_M;
            default:    state_next = MODE_RUN;
         endcase
      end
      if (blink_phase) begin
         if (in_set_h)      blink_o = MASK_HOUR;
         else if (in_set_m) blink_o = MASK_MIN;
      end
   end

   // Clear wins over a coincident tick: no pulse and no carry that cycle.
   assign tick = in_run & (presc == TICK_LAST) & ~clr_edge;

   always_ff @(posedge clk_i) begin
      if (rst_i || !in_run || clr_edge || presc == TICK_LAST) presc <= '0;
      else                                                    presc <= presc + TW'(1);
   end

   // Entering a set mode restarts the blink with digits visible.
   always_ff @(posedge clk_i) begin
      if (rst_i || state_next == MODE_RUN || state_next != state) begin
         blink_cnt   <= BLINK_LOAD;
         blink_phase <= 1'b0;
      end else if (blink_cnt == '0) begin
         blink_cnt   <= BLINK_LOAD;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt - BW'(1);
      end
   end

   // Leaving SET_M zeroes seconds so the first tick is a full period away.
   bcd_mod_counter u_sec (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (tick),
      .dec_i   (1'b0),
      .clr_i   (clr_edge | (in_set_m & mode_edge)),
      .max_i   (MAX_SEC),
      .value_o (sec_val),
      .carry_o (sec_carry)
   );

   bcd_mod_counter u_min (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   ((in_run & sec_carry) | (in_set_m & inc_edge)),
      .dec_i   (in_set_m & dec_edge),
      .clr_i   (1'b0),
      .max_i   (MAX_MIN),
      .value_o (min_val),
      .carry_o (min_carry)
   );

   bcd_mod_counter u_hour (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   ((in_run & min_carry) | (in_set_h & inc_edge)),
      .dec_i   (in_set_h & dec_edge),
      .clr_i   (1'b0),
      .max_i   (MAX_HOUR),
      .value_o (hour_val),
      .carry_o (hour_carry_unused)
   );

   assign bcd_o      = {hour_val, min_val};
   assign sec_bcd_o  = sec_val;
   assign mode_o     = state;
   assign sec_tick_o = tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
`timescale 1ns/1ps
module tb_clock_set_ctrl;

   localparam int T  = 4;
   localparam int B  = 8;
   localparam int RD = 10;
   localparam int RP = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  btn = 4'b0000;
   logic [15:0] bcd;
   logic [7:0]  sec;
   logic [1:0]  mode;
   logic [3:0]  blink;
   logic        tick;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int tick_cnt = 0;
   int t0;

   // Reference model: time as seconds-of-day. In RUN it is m_base plus
   // whole tick periods elapsed since m_e0; in set modes m_base is frozen.
   int m_mode = 0;
   int m_base = 0;
   int m_e0 = 0;
   int m_enter = 0;

   clock_set_ctrl #(
`ifdef AUTO_REPEAT_EN
      .REPEAT_DLY (RD),
      .REPEAT_PER (RP),
`endif
      .TICK_DIV   (T),
      .BLINK_DIV  (B)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .btn_i      (btn),
      .bcd_o      (bcd),
      .sec_bcd_o  (sec),
      .mode_o     (mode),
      .blink_o    (blink),
      .sec_tick_o (tick)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (tick === 1'b1) tick_cnt <= tick_cnt + 1;

   function automatic int now_time();
      if (m_mode == 0) return (m_base + (cyc - m_e0) / T) % 86400;
      return m_base;
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int          t;
      logic [15:0] eb;
      logic [3:0]  ebl;
      t   = now_time();
      eb  = {to_bcd(t / 3600), to_bcd((t / 60) % 60)};
      ebl = 4'b0000;
      if (m_mode != 0 && (((cyc - m_enter) / B) % 2) == 1)
         ebl = (m_mode == 1) ? 4'b1100 : 4'b0011;
      chk({tag, "_bcd"},   {16'h0, bcd},   {16'h0, eb});
      chk({tag, "_sec"},   {24'h0, sec},   {24'h0, to_bcd(t % 60)});
      chk({tag, "_mode"},  {30'h0, mode},  32'(m_mode));
      chk({tag, "_blink"}, {28'h0, blink}, {28'h0, ebl});
   endtask

   task automatic model_apply(input logic [3:0] m);
      int c, h, mi, s, d;
      c = cyc;
      if (m[3]) begin
         case (m_mode)
            0:       begin m_base = now_time(); m_mode = 1; m_enter = c; end
            1:       begin m_mode = 2; m_enter = c; end
            default: begin m_base = m_base - m_base % 60; m_mode = 0; m_e0 = c; end
         endcase
      end else if (m_mode == 0) begin
         if (m[2]) begin
            m_base = (m_base + (c - m_e0 - 1) / T) % 86400;
            m_base = m_base - m_base % 60;
            m_e0   = c;
         end
      end else if (m[1] ^ m[0]) begin
         d  = m[1] ? 1 : -1;
         h  = m_base / 3600;
         mi = (m_base / 60) % 60;
         s  = m_base % 60;
         if (m_mode == 1) h  = (h + d + 24) % 24;
         else             mi = (mi + d + 60) % 60;
         m_base = h * 3600 + mi * 60 + s;
      end
   endtask

   // One-sample button pulse; returns half a cycle after the update edge.
   task automatic press(input logic [3:0] m);
      btn = m;
      @(negedge clk);
      btn = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      model_apply(m);
   endtask

   task automatic hold(input logic [3:0] m, input int n);
      int steps;
      btn = m;
      repeat (n) @(negedge clk);
      btn = 4'b0000;
      repeat (3) @(negedge clk);
`ifdef AUTO_REPEAT_EN
      steps = 1 + ((n - 1 >= RD) ? (n - 1 - RD) / RP + 1 : 0);
`else
      steps = 1;
`endif
      for (int i = 0; i < steps; i++) model_apply(m);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      btn = 4'b0000;
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      m_mode = 0; m_base = 0; m_e0 = cyc; m_enter = cyc;
   endtask

   initial begin
      // reset
      do_reset(2);
      chk("rst_bcd",   {16'h0, bcd},  32'h0);
      chk("rst_sec",   {24'h0, sec},  32'h0);
      chk("rst_mode",  {30'h0, mode}, 32'h0);
      chk("rst_blink", {28'h0, blink}, 32'h0);
      chk("rst_tick",  {31'h0, tick}, 32'h0);

      // hour setting and wrap
      press(4'b1000);
      for (int i = 0; i < 23; i++) press(4'b0010);
      chk("h23", {16'h0, bcd}, 32'h2300);
      check_all("h23");
      press(4'b0010);
      chk("h_wrap_up", {16'h0, bcd}, 32'h0000);
      press(4'b0001);
      chk("h_wrap_dn", {16'h0, bcd}, 32'h2300);

      // 23:59 then one minute of running wraps the day
      press(4'b1000);
      for (int i = 0; i < 59; i++) press(4'b0010);
      press(4'b1000);
      chk("set_2359", {16'h0, bcd}, 32'h2359);
      chk("set_sec0", {24'h0, sec}, 32'h00);
      check_all("run_start");
      t0 = tick_cnt;
      wait_cyc(60 * T);
      chk("day_wrap_bcd", {16'h0, bcd}, 32'h0000);
      chk("day_wrap_sec", {24'h0, sec}, 32'h00);
      chk("tick_count_60", 32'(tick_cnt - t0), 32'd60);
      check_all("day_wrap");

      // freeze at :30, blink in SET_H, return to RUN with seconds cleared
      wait_cyc(30 * T - 3);
      press(4'b1000);
      chk("freeze_sec30", {24'h0, sec}, 32'h30);
      t0 = tick_cnt;
      for (int i = 0; i < 3 * B + 2; i++) begin
         @(negedge clk);
         check_all("blink_h");
      end
      chk("no_tick_in_set", 32'(tick_cnt - t0), 32'd0);
      press(4'b1000);
      press(4'b1000);
      chk("rerun_sec0", {24'h0, sec}, 32'h00);
      check_all("rerun");

      // simultaneous buttons
      press(4'b1000);
      press(4'b1000);
      press(4'b0011);
      check_all("incdec_setm");
      press(4'b1000);
      press(4'b1000);
      press(4'b1010);
      chk("mode_inc_mode", {30'h0, mode}, 32'd2);
      check_all("mode_inc");
      press(4'b1000);

      // held buttons in SET_M (auto-repeat when enabled, single step otherwise)
      press(4'b1000);
      press(4'b1000);
      hold(4'b0010, RD + 3 * RP);
      check_all("hold_inc");
      hold(4'b0001, RD + 2 * RP + 1);
      check_all("hold_dec");
      btn = 4'b0010;
      wait_cyc(RD + 4);
      rst = 1'b1;
      @(negedge clk);
      chk("hold_rst_bcd",  {16'h0, bcd},  32'h0);
      chk("hold_rst_mode", {30'h0, mode}, 32'h0);
      do_reset(1);
      wait_cyc(5);
      check_all("after_hold_rst");

      // randomized presses and waits against the model
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 8))
            0:       press(4'b1000);
            1, 2:    press(4'b0010);
            3:       press(4'b0001);
            4:       press(4'b0011);
            5:       press(4'b0100);
            6:       press(4'b1010);
            7:       press(4'b1100);
            default: wait_cyc($urandom_range(1, 40));
         endcase
         check_all("rand");
      end

      // reset with a mode press pending
      press(4'b1000);
      btn = 4'b1000;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_bcd",   {16'h0, bcd},   32'h0);
      chk("mid_rst_sec",   {24'h0, sec},   32'h0);
      chk("mid_rst_mode",  {30'h0, mode},  32'h0);
      chk("mid_rst_blink", {28'h0, blink}, 32'h0);
      do_reset(1);
      wait_cyc(6);
      check_all("edge_discarded");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
